// File: rtl/detector_seq_ctrl.sv
// Round-robin sequencer that feeds a test pattern serially into a Moore
// pattern detector and reports hit/miss. Optional counters: `define STATS_EN.
module detector_seq_ctrl #(
  parameter int PAT_W   = 4,
  parameter int TIMEOUT = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  // req/gnt: a requester holds req[i] high until it sees the one-cycle gnt[i]
  // pulse; its pattern is captured on the same edge that raises gnt[i].
  input  logic [1:0]       req,
  input  logic [PAT_W-1:0] pat0,
  input  logic [PAT_W-1:0] pat1,
  output logic [1:0]       gnt,
  output logic             det_rst_n,
  output logic             det_x,
  input  logic             det_out,
  output logic             done,
  output logic             hit,
  output logic             done_id,
  output logic [7:0]       hit_cnt,
  output logic [7:0]       miss_cnt,
  output logic [2:0]       state_dbg
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RESTART = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;

  logic [2:0]       state;
  logic [BW-1:0]    bit_idx;
  logic [TW-1:0]    tmo_cnt;
  logic [PAT_W-1:0] pat_q;
  logic             cur_id;
  logic             last_id;
  logic             pick_id;

  assign state_dbg = state;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick_id = req[1];
    if (req == 2'b11) begin
      pick_id = ~last_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_idx   <= '0;
      tmo_cnt   <= '0;
      pat_q     <= '0;
      cur_id    <= 1'b0;
      last_id   <= 1'b1;
      gnt       <= 2'b00;
      det_rst_n <= 1'b0;
      det_x     <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      done_id   <= 1'b0;
    end else begin
      gnt  <= 2'b00;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          det_rst_n <= 1'b1;
          det_x     <= 1'b0;
          if (|req) begin
            pat_q     <= pick_id ? pat1 : pat0;
            cur_id    <= pick_id;
            last_id   <= pick_id;
            gnt       <= pick_id ? 2'b10 : 2'b01;
            det_rst_n <= 1'b0;
            state     <= S_RESTART;
          end
        end
        S_RESTART: begin
          // Pattern is a left-shifting register so the MSB always feeds det_x.
          det_rst_n <= 1'b1;
          det_x     <= pat_q[PAT_W-1];
          pat_q     <= pat_q << 1;
          bit_idx   <= '0;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (det_out) begin
            det_x   <= 1'b0;
            done    <= 1'b1;
            hit     <= 1'b1;
            done_id <= cur_id;
            state   <= S_REPORT;
          end else if (bit_idx == BIT_LAST) begin
            det_x   <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            det_x   <= pat_q[PAT_W-1];
            pat_q   <= pat_q << 1;
          end
        end
        S_WAIT: begin
          det_x <= 1'b0;
          if (det_out || (tmo_cnt == TMO_LAST)) begin
            done    <= 1'b1;
            hit     <= det_out;
            done_id <= cur_id;
            state   <= S_REPORT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_REPORT: begin
          det_x <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          det_rst_n <= 1'b1;
          det_x     <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef STATS_EN
  // Counted while REPORT is presented, i.e. with the freshly updated hit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 8'd0;
      miss_cnt <= 8'd0;
    end else if (state == S_REPORT) begin
      if (hit) begin
        if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
`else
  assign hit_cnt  = 8'd0;
  assign miss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_detector_seq_ctrl.sv
// Directed plus randomized bench for detector_seq_ctrl; det_out is driven from a
// per-transaction schedule and results are predicted from cycle arithmetic.
module tb_detector_seq_ctrl;
  localparam int PAT_W   = 4;
  localparam int TIMEOUT = 12;
  localparam int MISS_LAT = PAT_W + TIMEOUT + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] pat0 = 4'h0;
  logic [3:0] pat1 = 4'h0;
  logic       det_out = 1'b0;
  logic [1:0] gnt;
  logic       det_rst_n, det_x, done, hit, done_id;
  logic [7:0] hit_cnt, miss_cnt;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  int last_served = 1;
  int n_hit = 0;
  int n_miss = 0;

  detector_seq_ctrl #(.PAT_W(PAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pat0(pat0), .pat1(pat1),
    .gnt(gnt), .det_rst_n(det_rst_n), .det_x(det_x), .det_out(det_out),
    .done(done), .hit(hit), .done_id(done_id),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters();
`ifdef STATS_EN
    check("hit_cnt", 32'(hit_cnt), (n_hit > 255) ? 32'd255 : 32'(n_hit));
    check("miss_cnt", 32'(miss_cnt), (n_miss > 255) ? 32'd255 : 32'(n_miss));
`else
    check("hit_cnt", 32'(hit_cnt), 32'd0);
    check("miss_cnt", 32'(miss_cnt), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_det_rst_n"}, 32'(det_rst_n), 32'd0);
    check({tag, "_det_x"}, 32'(det_x), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_hit"}, 32'(hit), 32'd0);
    check({tag, "_done_id"}, 32'(done_id), 32'd0);
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
    check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'd0);
  endtask

  // hit_at: index (1-based) of the SHIFT/WAIT cycle in which det_out is high; 0 = never.
  task automatic run_txn(input logic [1:0] r, input logic [3:0] p0, input logic [3:0] p1,
                         input int hit_at, input bit hold);
    int id;
    int exp_j;
    int seen;
    logic [3:0] pat;
    logic [1:0] exp;
    id    = (r == 2'b11) ? (1 - last_served) : (r[1] ? 1 : 0);
    pat   = (id == 1) ? p1 : p0;
    exp_j = (hit_at > 0) ? hit_at + 1 : MISS_LAT;
    exp_q.push_back({(hit_at > 0), id[0]});
    req = r; pat0 = p0; pat1 = p1; det_out = 1'b0;

    seen = 0;
    for (int k = 0; k < 6 && seen == 0; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) seen = 1;
    end
    check("gnt_seen", 32'(seen), 32'd1);
    check("gnt_onehot", 32'(gnt), (id == 1) ? 32'd2 : 32'd1);
    check("restart_low", 32'(det_rst_n), 32'd0);
    check("done_at_gnt", 32'(done), 32'd0);
    last_served = id;
    if (!hold) req = 2'b00;
    pat0 = 4'($urandom);
    pat1 = 4'($urandom);

    seen = 0;
    for (int j = 1; j <= MISS_LAT + 4 && seen == 0; j++) begin
      @(negedge clk);
      det_out = (j == hit_at);
      if (j == 1) check("gnt_pulse", 32'(gnt), 32'd0);
      if (done) begin
        seen = 1;
        check("done_latency", 32'(j), 32'(exp_j));
        exp = exp_q.pop_front();
        check("hit", 32'(hit), 32'(exp[1]));
        check("done_id", 32'(done_id), 32'(exp[0]));
        check("report_det_x", 32'(det_x), 32'd0);
        if (exp[1]) n_hit++; else n_miss++;
      end else begin
        check("det_x", 32'(det_x), (j <= PAT_W) ? 32'(pat[PAT_W-j]) : 32'd0);
        check("det_rst_n_run", 32'(det_rst_n), 32'd1);
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen == 0 && exp_q.size() > 0) exp = exp_q.pop_front();
    det_out = 1'b0;

    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("hit_hold", 32'(hit), 32'(exp[1]));
    check("done_id_hold", 32'(done_id), 32'(exp[0]));
    check_counters();
  endtask

  initial begin
    int hit_at;
    int seen;
    logic [1:0] r;

    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_det_rst_n", 32'(det_rst_n), 32'd1);

    // Directed: requester 0, pattern 1001, detector flags 3 cycles after last bit
    run_txn(2'b01, 4'b1001, 4'b0110, PAT_W + 3, 1'b0);

    // Directed: both requesting, held -> alternating grants
    run_txn(2'b11, 4'hA, 4'h5, 0, 1'b1);
    run_txn(2'b11, 4'hA, 4'h5, 3, 1'b1);
    run_txn(2'b11, 4'h3, 4'hC, 6, 1'b1);
    req = 2'b00;
    @(negedge clk);

    // Directed: requester 1, no flag -> timeout miss
    run_txn(2'b10, 4'h0, 4'hF, 0, 1'b0);

    // Directed: flag at end of 2nd SHIFT cycle aborts the shift
    run_txn(2'b01, 4'b1111, 4'b0000, 2, 1'b0);

    // Directed: reset in the middle of SHIFT
    req = 2'b01; pat0 = 4'hB;
    seen = 0;
    for (int k = 0; k < 6 && seen == 0; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) seen = 1;
    end
    check("midrst_gnt_seen", 32'(seen), 32'd1);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    last_served = 1; n_hit = 0; n_miss = 0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("postrst_no_done", 32'(done), 32'd0);
    end
    run_txn(2'b01, 4'b0101, 4'b1010, 5, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       r = 2'b01;
        1:       r = 2'b10;
        default: r = 2'b11;
      endcase
      hit_at = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, PAT_W + TIMEOUT));
      run_txn(r, 4'($urandom), 4'($urandom), hit_at, 1'b0);
    end

    // Saturation run: many quick hits
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      run_txn(r, 4'($urandom), 4'($urandom), int'($urandom_range(1, PAT_W)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
